round_robin_arbiter_4: RTL and testbench



---
 rtl/arb_pkg.sv | 37 +++
 rtl/round_robin_arbiter_4_decoder.sv | 28 ++
 rtl/round_robin_arbiter_4.sv | 115 +++++++++++
 tb/tb_round_robin_arbiter_4.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
// Holds the requester count, the index and hold-counter widths, the
// two-state FSM encoding, and the rotating-priority selection helper.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Returns the first set request bit in the order ptr, ptr+1, ptr+2, ptr+3
    // (mod N_REQ). The loop runs from the farthest offset down to offset 0 so
    // the closest requester to ptr is written last and wins. If no bit is set,
    // ptr itself is returned; callers only use the result when req != 0.
    function automatic logic [IDX_W-1:0] rr_select(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        sel = ptr;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            idx = ptr + j[IDX_W-1:0];
            if (req[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_4_decoder.sv
// decoder2to4withEnable: 2-to-4 one-hot decoder with an enable.
// Ports:
//   A  - 2-bit binary index
//   En - enable; when low the output is all zeros
//   Y  - one-hot output, Y[A] = 1 when En is high
module decoder2to4withEnable (
    input  logic [1:0] A,
    input  logic       En,
    output logic [3:0] Y
);

    // One-hot decode of A, forced to zero when disabled.
    always_comb begin
        Y = 4'b0000;
        if (En) begin
            case (A)
                2'd0:    Y = 4'b0001;
                2'd1:    Y = 4'b0010;
                2'd2:    Y = 4'b0100;
                2'd3:    Y = 4'b1000;
                default: Y = 4'b0000;
            endcase
        end else begin
            Y = 4'b0000;
        end
    end

endmodule

// File: rtl/round_robin_arbiter_4.sv
// round_robin_arbiter_4: four-requester round-robin arbiter with a bounded
// hold time. A requester keeps its grant while it holds req high; once it has
// held the grant for MAX_HOLD cycles and someone else is waiting, the grant is
// revoked and preempt pulses. Every release inserts one idle cycle.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   req     - request per requester (bit i = requester i)
//   gnt     - one-hot grant, zero when idle
//   gnt_idx - index of the current or most recent owner
//   busy    - high while a grant is asserted
//   preempt - one-cycle pulse on the cycle after a MAX_HOLD revocation
module round_robin_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic              r_busy;
    logic              r_preempt;

    logic [IDX_W-1:0]  w_sel;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_owner_req;
    logic              w_other_req;
    logic              w_hold_full;

    // gnt is a pure decode of registered state, so req never reaches it.
    decoder2to4withEnable u_gnt_dec (
        .A  (r_gnt_idx),
        .En (r_busy),
        .Y  (w_gnt)
    );

    assign w_sel       = rr_select(req, r_ptr);
    assign w_owner_req = req[r_gnt_idx];
    // Only meaningful in BUSY, where w_gnt masks out the owner's own bit.
    assign w_other_req = |(req & ~w_gnt);
    assign w_hold_full = (r_hold_cnt == HOLD_LIM);

    // Arbitration FSM with pointer, hold counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt_idx  <= '0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_preempt <= 1'b0;
                    if (|req) begin
                        r_state    <= BUSY;
                        r_busy     <= 1'b1;
                        r_gnt_idx  <= w_sel;
                        r_ptr      <= w_sel + IDX_W'(1);
                        r_hold_cnt <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!w_owner_req) begin
                        // Owner finished: normal release.
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_preempt <= 1'b0;
                    end else if (w_hold_full && w_other_req) begin
                        // Hold budget spent and someone waits: revoke.
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_preempt <= 1'b1;
                    end else begin
                        // Keep the grant; the counter saturates so a lone
                        // owner is preempted as soon as a rival shows up.
                        r_preempt <= 1'b0;
                        if (!w_hold_full) begin
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_preempt <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = w_gnt;
    assign gnt_idx = r_gnt_idx;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Bench for round_robin_arbiter_4. Three instances with MAX_HOLD = 4, 2, 1
// share clock and reset. A behavioural model tracks owner, pointer and the
// number of cycles the current grant has been visible, and a negedge process
// compares every output of every instance against it each cycle. Directed
// scenarios add literal expectations that pin the model.
module tb_round_robin_arbiter_4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmp_en = 1'b0;

    logic [3:0] req_v   [3];
    logic [3:0] gnt_v   [3];
    logic [1:0] idx_v   [3];
    logic       busy_v  [3];
    logic       pre_v   [3];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit m_busy  [3];
    int m_owner [3];
    int m_ptr   [3];
    int m_held  [3];
    bit m_pre   [3];

    always #5 clk = ~clk;

    round_robin_arbiter_4 #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_v[0]), .gnt(gnt_v[0]),
        .gnt_idx(idx_v[0]), .busy(busy_v[0]), .preempt(pre_v[0])
    );
    round_robin_arbiter_4 #(.MAX_HOLD(2)) dut_b (
        .clk(clk), .rst(rst), .req(req_v[1]), .gnt(gnt_v[1]),
        .gnt_idx(idx_v[1]), .busy(busy_v[1]), .preempt(pre_v[1])
    );
    round_robin_arbiter_4 #(.MAX_HOLD(1)) dut_c (
        .clk(clk), .rst(rst), .req(req_v[2]), .gnt(gnt_v[2]),
        .gnt_idx(idx_v[2]), .busy(busy_v[2]), .preempt(pre_v[2])
    );

    function automatic int mh(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // first requester found scanning p, p+1, p+2, p+3 (mod 4)
    function automatic int pick(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // behavioural model
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k]  <= 1'b0;
                m_owner[k] <= 0;
                m_ptr[k]   <= 0;
                m_held[k]  <= 0;
                m_pre[k]   <= 1'b0;
            end else if (!m_busy[k]) begin
                m_pre[k] <= 1'b0;
                if (req_v[k] != 4'b0000) begin
                    m_busy[k]  <= 1'b1;
                    m_owner[k] <= pick(req_v[k], m_ptr[k]);
                    m_ptr[k]   <= (pick(req_v[k], m_ptr[k]) + 1) % 4;
                    m_held[k]  <= 1;
                end
            end else if (!req_v[k][m_owner[k]]) begin
                m_busy[k] <= 1'b0;
                m_pre[k]  <= 1'b0;
            end else if (m_held[k] >= mh(k) &&
                         (req_v[k] & ~(4'b0001 << m_owner[k])) != 4'b0000) begin
                m_busy[k] <= 1'b0;
                m_pre[k]  <= 1'b1;
            end else begin
                m_held[k] <= m_held[k] + 1;
                m_pre[k]  <= 1'b0;
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("model_gnt[%0d]", k), 32'(gnt_v[k]),
                          m_busy[k] ? 32'(4'b0001 << m_owner[k]) : 32'd0);
                    check($sformatf("model_idx[%0d]", k), 32'(idx_v[k]), 32'(m_owner[k]));
                    check($sformatf("model_busy[%0d]", k), 32'(busy_v[k]), 32'(m_busy[k]));
                    check($sformatf("model_pre[%0d]", k), 32'(pre_v[k]), 32'(m_pre[k]));
                end
            end
        end
    end

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int k = 0; k < 3; k++) req_v[k] = 4'b0000;
        #1;
        rst    = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // reset state
        check("rst_gnt",  32'(gnt_v[0]),  32'd0);
        check("rst_idx",  32'(idx_v[0]),  32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_pre",  32'(pre_v[0]),  32'd0);

        // single request: one-cycle latency, release next cycle
        req_v[0] = 4'b0001;
        tick();
        check("single_gnt", 32'(gnt_v[0]), 32'h1);
        check("single_idx", 32'(idx_v[0]), 32'd0);
        req_v[0] = 4'b0000;
        tick();
        check("single_rel_gnt",  32'(gnt_v[0]),  32'd0);
        check("single_rel_busy", 32'(busy_v[0]), 32'd0);

        // fairness with ptr back at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_v[0] = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fair_idx%0d", i), 32'(idx_v[0]), 32'(order[i]));
            check($sformatf("fair_busy%0d", i), 32'(busy_v[0]), 32'd1);
            tick();
            req_v[0][order[i]] = 1'b0;
            tick();
            check($sformatf("fair_gap%0d", i), 32'(busy_v[0]), 32'd0);
            req_v[0][order[i]] = 1'b1;
            tick();
        end
        req_v[0] = 4'b0000;
        tick();

        // wrap-around: grant 2 leaves ptr at 3, search 3,0 picks 0
        req_v[0] = 4'b0100;
        tick();
        check("wrap_pre_gnt", 32'(gnt_v[0]), 32'h4);
        req_v[0] = 4'b0000;
        tick();
        req_v[0] = 4'b0101;
        tick();
        check("wrap_gnt", 32'(gnt_v[0]), 32'h1);
        check("wrap_idx", 32'(idx_v[0]), 32'd0);
        req_v[0] = 4'b0000;
        tick();

        // preemption with MAX_HOLD=4
        req_v[0] = 4'b0001;
        tick();
        check("pre_c1_gnt", 32'(gnt_v[0]), 32'h1);
        req_v[0] = 4'b0101;
        tick();
        tick();
        tick();
        check("pre_c4_gnt", 32'(gnt_v[0]), 32'h1);
        tick();
        check("pre_pulse",     32'(pre_v[0]),  32'd1);
        check("pre_idle_busy", 32'(busy_v[0]), 32'd0);
        check("pre_idle_gnt",  32'(gnt_v[0]),  32'd0);
        tick();
        check("pre_next_gnt", 32'(gnt_v[0]), 32'h4);
        check("pre_next_pre", 32'(pre_v[0]), 32'd0);
        req_v[0] = 4'b0000;
        tick();
        tick();

        // asynchronous reset mid-grant
        req_v[0] = 4'b0010;
        tick();
        check("arst_pre_gnt", 32'(gnt_v[0]), 32'h2);
        #1;
        rst = 1'b1;
        #1;
        check("arst_gnt",  32'(gnt_v[0]),  32'd0);
        check("arst_busy", 32'(busy_v[0]), 32'd0);
        check("arst_pre",  32'(pre_v[0]),  32'd0);
        req_v[0] = 4'b1010;
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        check("arst_ptr0_gnt", 32'(gnt_v[0]), 32'h2);
        req_v[0] = 4'b0000;
        tick();

        // lone requester with MAX_HOLD=2 keeps its grant
        req_v[1] = 4'b1000;
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("lone_gnt%0d", i), 32'(gnt_v[1]), 32'h8);
            check($sformatf("lone_pre%0d", i), 32'(pre_v[1]), 32'd0);
            tick();
        end
        req_v[1] = 4'b1001;
        tick();
        check("lone_late_pre",  32'(pre_v[1]),  32'd1);
        check("lone_late_busy", 32'(busy_v[1]), 32'd0);
        tick();
        check("lone_late_gnt", 32'(gnt_v[1]), 32'h1);
        req_v[1] = 4'b0000;
        tick();

        // MAX_HOLD=1: preempt after a single grant cycle
        req_v[2] = 4'b0011;
        tick();
        check("mh1_gnt0", 32'(gnt_v[2]), 32'h1);
        tick();
        check("mh1_pre",  32'(pre_v[2]),  32'd1);
        check("mh1_busy", 32'(busy_v[2]), 32'd0);
        tick();
        check("mh1_gnt1", 32'(gnt_v[2]), 32'h2);
        req_v[2] = 4'b0000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
